// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and slave endpoints: FSM states, word size, divider limits.
package spi_pkg;

   localparam int unsigned SPI_BITS    = 8;
   localparam int unsigned BIT_CNT_W   = $clog2(SPI_BITS);
   localparam int unsigned CLK_DIV_MIN = 2;
   localparam int unsigned CLK_DIV_MAX = 255;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      TRANSFER = 2'd2,
      HOLD     = 2'd3
   } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: counts CLK_DIV cycles per half-period and flags leading/trailing edges
// in the same cycle sclk is toggled, so the master can act on the edge itself.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic toggle_i,
   input  logic cpol_i,
   output logic sclk_o,
   output logic tick_c_o,
   output logic lead_c_o,
   output logic trail_c_o
);

   localparam int unsigned DIV   = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN :
                                   (CLK_DIV > CLK_DIV_MAX) ? CLK_DIV_MAX : CLK_DIV;
   localparam int unsigned CNT_W = $clog2(DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sclk_q, sclk_d;
   logic             edge_c;

   assign tick_c_o  = en_i && (cnt_q == CNT_W'(DIV - 1));
   assign edge_c    = tick_c_o && toggle_i;
   assign lead_c_o  = edge_c && (sclk_q == cpol_i);
   assign trail_c_o = edge_c && (sclk_q != cpol_i);
   assign sclk_o    = sclk_q;

   // While disabled the counter is parked at zero and sclk tracks the idle level.
   always_comb begin
      cnt_d  = '0;
      sclk_d = cpol_i;
      if (en_i) begin
         cnt_d  = tick_c_o ? '0 : cnt_q + CNT_W'(1);
         sclk_d = edge_c ? ~sclk_q : sclk_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/spi_master.sv
// Byte-wide SPI master, CPHA=0 (modes 0 and 2) with per-transfer SCLK polarity.
// Define SPI_LSB_FIRST_EN for LSB-first bit order; the default build is MSB first.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                cpol,
   input  logic [SPI_BITS-1:0] data_in,
   output logic [SPI_BITS-1:0] data_out,
   output logic                busy,
   output logic                done,
   output logic                ss,
   output logic                sclk,
   output logic                mosi,
   input  logic                miso
);

`ifdef SPI_LSB_FIRST_EN
   function automatic logic first_bit(input logic [SPI_BITS-1:0] d);
      return d[0];
   endfunction
   function automatic logic [SPI_BITS-1:0] shift_tx(input logic [SPI_BITS-1:0] d);
      return d >> 1;
   endfunction
   function automatic logic [SPI_BITS-1:0] shift_rx(input logic [SPI_BITS-1:0] r, input logic b);
      return {b, r[SPI_BITS-1:1]};
   endfunction
`else
   function automatic logic first_bit(input logic [SPI_BITS-1:0] d);
      return d[SPI_BITS-1];
   endfunction
   function automatic logic [SPI_BITS-1:0] shift_tx(input logic [SPI_BITS-1:0] d);
      return d << 1;
   endfunction
   function automatic logic [SPI_BITS-1:0] shift_rx(input logic [SPI_BITS-1:0] r, input logic b);
      return {r[SPI_BITS-2:0], b};
   endfunction
`endif

   spi_state_e           state_q, state_d;
   logic [SPI_BITS-1:0]  tx_q, tx_d;
   logic [SPI_BITS-1:0]  rx_q, rx_d;
   logic [SPI_BITS-1:0]  data_out_q, data_out_d;
   logic [BIT_CNT_W-1:0] bit_q, bit_d;
   logic                 cpol_q, cpol_d;
   logic                 ss_q, ss_d;
   logic                 mosi_q, mosi_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 div_en, div_toggle, div_cpol;
   logic                 tick, lead, trail;

   // The SETUP interval ends on the first leading edge, so toggling is enabled there too.
   assign div_en     = (state_q != IDLE);
   assign div_toggle = (state_q == SETUP) || (state_q == TRANSFER);
   assign div_cpol   = (state_q == IDLE) ? cpol : cpol_q;

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk       (clk),
      .rst       (rst),
      .en_i      (div_en),
      .toggle_i  (div_toggle),
      .cpol_i    (div_cpol),
      .sclk_o    (sclk),
      .tick_c_o  (tick),
      .lead_c_o  (lead),
      .trail_c_o (trail)
   );

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      data_out_d = data_out_q;
      bit_d      = bit_q;
      cpol_d     = cpol_q;
      ss_d       = ss_q;
      mosi_d     = mosi_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            ss_d = 1'b1;
            if (en) begin
               tx_d    = data_in;
               rx_d    = '0;
               cpol_d  = cpol;
               ss_d    = 1'b0;
               mosi_d  = first_bit(data_in);
               bit_d   = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (lead) begin
               rx_d    = shift_rx(rx_q, miso);
               state_d = TRANSFER;
            end
         end
         TRANSFER: begin
            if (lead) begin
               rx_d = shift_rx(rx_q, miso);
            end else if (trail) begin
               if (bit_q == BIT_CNT_W'(SPI_BITS - 1)) begin
                  state_d = HOLD;
               end else begin
                  bit_d  = bit_q + BIT_CNT_W'(1);
                  tx_d   = shift_tx(tx_q);
                  mosi_d = first_bit(shift_tx(tx_q));
               end
            end
         end
         HOLD: begin
            if (tick) begin
               ss_d       = 1'b1;
               data_out_d = rx_q;
               done_d     = 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            ss_d    = 1'b1;
            state_d = IDLE;
         end
      endcase

      // busy stays up through the done cycle and across a back-to-back accept.
      busy_d = (state_d != IDLE) || done_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_q       <= '0;
         rx_q       <= '0;
         data_out_q <= '0;
         bit_q      <= '0;
         cpol_q     <= 1'b0;
         ss_q       <= 1'b1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         data_out_q <= data_out_d;
         bit_q      <= bit_d;
         cpol_q     <= cpol_d;
         ss_q       <= ss_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign data_out = data_out_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign ss       = ss_q;
   assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master with a CPHA=0 slave model and a scoreboard of expected bytes.
module tb_spi_master;

   localparam int unsigned DIV      = 4;
   localparam int          EXP_DONE = 1 + 17 * int'(DIV);
   localparam int          EXP_SSLO = 17 * int'(DIV);

   logic       clk = 1'b0;
   logic       rst, en, cpol, miso;
   logic [7:0] data_in, data_out;
   logic       busy, done, ss, sclk, mosi;

   logic       loopback;
   logic       cur_cpol;
   logic [7:0] slv_byte;
   int         slv_idx = 0;
   logic       slv_bit;
   logic [7:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   spi_master #(.CLK_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .en(en), .cpol(cpol), .data_in(data_in),
      .data_out(data_out), .busy(busy), .done(done), .ss(ss),
      .sclk(sclk), .mosi(mosi), .miso(miso)
   );

   always #5 clk = ~clk;

   function automatic int bit_pos(input int i);
`ifdef SPI_LSB_FIRST_EN
      return i;
`else
      return 7 - i;
`endif
   endfunction

   // Byte rearranged so that the first bit on the wire sits in bit 7.
   function automatic logic [7:0] tx_order(input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++) r[7-i] = b[bit_pos(i)];
      return r;
   endfunction

   // CPHA=0 slave: bit index advances on each trailing edge while selected.
   always begin
      @(negedge ss);
      slv_idx = 0;
      while (ss === 1'b0) begin
         @(sclk or ss);
         if (ss === 1'b0 && sclk === cur_cpol) slv_idx++;
      end
   end

   always_comb begin
      slv_bit = 1'b0;
      if (slv_idx >= 0 && slv_idx < 8) slv_bit = slv_byte[bit_pos(slv_idx)];
   end

   assign miso = loopback ? mosi : slv_bit;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "simulation did not finish");
   end

   // Called at a falling edge; returns at the falling edge of cycle 1 of the transfer.
   task automatic start_xfer(input logic [7:0] d, input logic cp);
      data_in  = d;
      cpol     = cp;
      cur_cpol = cp;
      en       = 1'b1;
      @(negedge clk);
      en = 1'b0;
   endtask

   // Watches one transfer from cycle 1 until done; returns at the falling edge of the done cycle.
   task automatic observe_xfer(input logic cpol_v, input int pulse_at,
                               output int done_cyc, output int ss_low, output int edges,
                               output logic [7:0] mosi_bits, output logic [7:0] rx,
                               output logic timeout);
      logic prev_sclk;
      done_cyc = 0; ss_low = 0; edges = 0; mosi_bits = 8'h00; rx = 8'h00; timeout = 1'b1;
      prev_sclk = cpol_v;
      for (int c = 1; c <= 300; c++) begin
         if (ss === 1'b0) ss_low++;
         if (sclk !== prev_sclk) begin
            edges++;
            if (prev_sclk === cpol_v) mosi_bits = {mosi_bits[6:0], mosi};
            prev_sclk = sclk;
         end
         if (done === 1'b1) begin
            done_cyc = c;
            rx       = data_out;
            timeout  = 1'b0;
            break;
         end
         en = (c == pulse_at);
         if (c == pulse_at) data_in = ~data_in;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b0; cpol = 1'b1; cur_cpol = 1'b1; data_in = 8'h00;
      loopback = 1'b1; slv_byte = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if ({ss, sclk, mosi, busy, done, data_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_values got ss=%b sclk=%b mosi=%b busy=%b done=%b dout=%h",
                  ss, sclk, mosi, busy, done, data_out);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (sclk !== 1'b1) begin
         errors++;
         $display("FAIL reset_sclk_follows_cpol got %b exp 1", sclk);
      end
      cpol = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mode0;
      int dc, sl, ed; logic [7:0] mb, rx, exp_b; logic to;
      loopback = 1'b1;
      exp_q.push_back(8'hA5);
      start_xfer(8'hA5, 1'b0);
      checks++;
      if ({ss, busy, mosi} !== {1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL mode0_start got ss=%b busy=%b mosi=%b exp 0 1 1", ss, busy, mosi);
      end
      observe_xfer(1'b0, 0, dc, sl, ed, mb, rx, to);
      checks++;
      if (to) begin errors++; $display("FAIL mode0_timeout got no done exp done"); end
      checks++;
      if (dc !== EXP_DONE) begin errors++; $display("FAIL mode0_done_cycle got %0d exp %0d", dc, EXP_DONE); end
      checks++;
      if (ed !== 16) begin errors++; $display("FAIL mode0_edges got %0d exp 16", ed); end
      checks++;
      if (mb !== tx_order(8'hA5)) begin errors++; $display("FAIL mode0_mosi_seq got %h exp %h", mb, tx_order(8'hA5)); end
      checks++;
      if (sl !== EXP_SSLO) begin errors++; $display("FAIL mode0_ss_low got %0d exp %0d", sl, EXP_SSLO); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mode0_busy_at_done got %b exp 1", busy); end
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rx !== exp_b) begin errors++; $display("FAIL mode0_data_out got %h exp %h", rx, exp_b); end
      @(negedge clk);
      checks++;
      if ({done, busy, ss} !== {1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL mode0_after_done got done=%b busy=%b ss=%b exp 0 0 1", done, busy, ss);
      end
   endtask

   task automatic test_mode2;
      int dc, sl, ed; logic [7:0] mb, rx, exp_b; logic to;
      loopback = 1'b0; slv_byte = 8'hC3;
      cpol = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (sclk !== 1'b1) begin errors++; $display("FAIL mode2_idle_sclk got %b exp 1", sclk); end
      exp_q.push_back(8'hC3);
      start_xfer(8'h3C, 1'b1);
      observe_xfer(1'b1, 0, dc, sl, ed, mb, rx, to);
      checks++;
      if (to) begin errors++; $display("FAIL mode2_timeout got no done exp done"); end
      checks++;
      if (ed !== 16) begin errors++; $display("FAIL mode2_edges got %0d exp 16", ed); end
      checks++;
      if (mb !== tx_order(8'h3C)) begin errors++; $display("FAIL mode2_mosi_seq got %h exp %h", mb, tx_order(8'h3C)); end
      checks++;
      if (sclk !== 1'b1) begin errors++; $display("FAIL mode2_sclk_at_done got %b exp 1", sclk); end
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rx !== exp_b) begin errors++; $display("FAIL mode2_data_out got %h exp %h", rx, exp_b); end
      @(negedge clk);
   endtask

   task automatic test_en_ignored;
      int dc, sl, ed, extra; logic [7:0] mb, rx, exp_b; logic to, ss_hi;
      loopback = 1'b1; cpol = 1'b0;
      @(negedge clk);
      exp_q.push_back(8'h5A);
      start_xfer(8'h5A, 1'b0);
      observe_xfer(1'b0, 10, dc, sl, ed, mb, rx, to);
      checks++;
      if (dc !== EXP_DONE) begin errors++; $display("FAIL enign_done_cycle got %0d exp %0d", dc, EXP_DONE); end
      checks++;
      if (sl !== EXP_SSLO) begin errors++; $display("FAIL enign_ss_low got %0d exp %0d", sl, EXP_SSLO); end
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rx !== exp_b) begin errors++; $display("FAIL enign_data_out got %h exp %h", rx, exp_b); end
      extra = 0; ss_hi = 1'b1;
      repeat (80) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
         if (ss !== 1'b1) ss_hi = 1'b0;
      end
      checks++;
      if (extra !== 0 || ss_hi !== 1'b1) begin
         errors++;
         $display("FAIL enign_no_second got extra_done=%0d ss_stayed_high=%b exp 0 1", extra, ss_hi);
      end
   endtask

   task automatic test_single_bit;
      int dc, sl, ed; logic [7:0] mb, rx, exp_b; logic to;
      loopback = 1'b0; slv_byte = 8'h01;
      exp_q.push_back(8'h01);
      start_xfer(8'h01, 1'b0);
      observe_xfer(1'b0, 0, dc, sl, ed, mb, rx, to);
      checks++;
      if (mb !== tx_order(8'h01)) begin errors++; $display("FAIL onebit_mosi_seq got %h exp %h", mb, tx_order(8'h01)); end
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rx !== exp_b) begin errors++; $display("FAIL onebit_data_out got %h exp %h", rx, exp_b); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int dc, sl, ed; logic [7:0] mb, rx, exp_b; logic to;
      loopback = 1'b1; cpol = 1'b1;
      @(negedge clk);
      start_xfer(8'h96, 1'b1);
      repeat (29) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({ss, sclk, busy, done, data_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL rstmid_values got ss=%b sclk=%b busy=%b done=%b dout=%h", ss, sclk, busy, done, data_out);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_q.push_back(8'h69);
      start_xfer(8'h69, 1'b1);
      observe_xfer(1'b1, 0, dc, sl, ed, mb, rx, to);
      checks++;
      if (dc !== EXP_DONE) begin errors++; $display("FAIL rstmid_done_cycle got %0d exp %0d", dc, EXP_DONE); end
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rx !== exp_b) begin errors++; $display("FAIL rstmid_data_out got %h exp %h", rx, exp_b); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int dc, sl, ed; logic [7:0] mb, rx, exp_b; logic to;
      loopback = 1'b1; cpol = 1'b0;
      @(negedge clk);
      exp_q.push_back(8'h3C);
      start_xfer(8'h3C, 1'b0);
      observe_xfer(1'b0, 0, dc, sl, ed, mb, rx, to);
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rx !== exp_b) begin errors++; $display("FAIL b2b_first_data_out got %h exp %h", rx, exp_b); end
      checks++;
      if (ss !== 1'b1) begin errors++; $display("FAIL b2b_ss_high_at_done got %b exp 1", ss); end
      exp_q.push_back(8'hFF);
      start_xfer(8'hFF, 1'b0);
      checks++;
      if ({ss, busy} !== {1'b0, 1'b1}) begin
         errors++;
         $display("FAIL b2b_accept got ss=%b busy=%b exp 0 1", ss, busy);
      end
      observe_xfer(1'b0, 0, dc, sl, ed, mb, rx, to);
      checks++;
      if (dc !== EXP_DONE) begin errors++; $display("FAIL b2b_done_cycle got %0d exp %0d", dc, EXP_DONE); end
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rx !== exp_b) begin errors++; $display("FAIL b2b_second_data_out got %h exp %h", rx, exp_b); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode2();
      test_en_ignored();
      test_single_bit();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_master.md
# spi_master

Byte-wide SPI master (initiator) that drives the serial bus toward an SPI slave endpoint. It accepts a byte on a one-cycle start request, generates SCLK from the system clock with programmable polarity, shifts the byte out on MOSI while capturing MISO, and returns the received byte with a one-cycle completion pulse. The block sits between the local controller and the off-chip or on-chip SPI slave.

## Interface
- CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  start request; sampled in IDLE only.
- cpol  input  1  SCLK idle level; latched when a transfer starts.
- data_in  input  8  byte to transmit; latched with en.
- data_out  output  8  last received byte; updated at end of transfer.
- busy  output  1  high from the cycle after en is accepted until the cycle done is asserted, inclusive.
- done  output  1  one-cycle pulse at transfer completion.
- ss  output  1  slave select, active low.
- sclk  output  1  serial clock.
- mosi  output  1  serial data out.
- miso  input  1  serial data in; treated as synchronous to sclk edges generated here.

## Operation
- SPI mode CPHA=0 only (modes 0 and 2): first bit valid before first SCLK edge; sample on leading edge, shift on trailing edge.
- States: IDLE, SETUP, TRANSFER, HOLD.
- IDLE: ss=1, busy=0, sclk follows cpol (registered). en=1 -> latch data_in to tx shift register, latch cpol, drive ss=0, drive mosi with first bit, clear bit counter, go to SETUP.
- SETUP: hold CLK_DIV cycles (ss-to-first-edge), then TRANSFER.
- TRANSFER: divider toggles sclk every CLK_DIV cycles; 16 toggles total. Leading edge (sclk leaves latched cpol): shift miso into rx shift register. Trailing edge: if bit counter = 7 go to HOLD, else increment counter and present next bit on mosi.
- HOLD: hold CLK_DIV cycles with sclk at idle level, then ss=1, data_out <= rx register, done=1 for one cycle, go to IDLE.
- en while busy: ignored, no queueing. cpol/data_in changes while busy: ignored.
- Illegal state encoding: return to IDLE next cycle.
- rst at any time: all outputs to reset values immediately; partial transfer discarded, data_out cleared.

## Timing
- Reset values: ss=1, sclk=0, mosi=0, busy=0, done=0, data_out=8'h00; state IDLE. First cycle after reset release sclk takes cpol.
- Cycle 0 = rising edge sampling en=1. ss falls and mosi presents bit 0 of the order at cycle 1.
- First sclk edge at cycle 1+CLK_DIV; edges every CLK_DIV cycles; last (16th) edge at cycle 1+16·CLK_DIV.
- done and data_out update at cycle 1+17·CLK_DIV; ss rises same cycle.
- A new en may be accepted the cycle after done; minimum ss high time is therefore 1 cycle.
- mosi changes only on trailing edges or at transfer start; stable across every leading edge.

## Configuration
- SPI_LSB_FIRST_EN defined: bit 0 of data_in transmitted first; first received bit lands in data_out[0].
- Not defined (default): MSB first on both mosi and miso; first received bit lands in data_out[7].

## Structure
- Shared package spi_pkg: state encodings (IDLE, SETUP, TRANSFER, HOLD), SPI_BITS=8, CLK_DIV minimum constant; shared with the slave endpoint.
- One sub-module spi_clk_gen: CLK_DIV counter producing sclk plus single-cycle leading/trailing edge strobes, enable and cpol inputs.

## Test plan
- Mode 0, MSB first, CLK_DIV=4, data_in=8'hA5, miso looped to mosi -> mosi sequence 1,0,1,0,0,1,0,1; data_out=8'hA5; done at cycle 69 after en.
- Mode 2 (cpol=1), data_in=8'h3C, miso tied to 8'hC3 pattern from slave model -> sclk idles high, 16 edges, data_out=8'hC3.
- en pulsed again at cycle 10 of an active transfer -> ignored; exactly one done, ss low for 68 cycles only.
- rst asserted at cycle 30 mid-transfer -> ss=1, sclk=0, busy=0, data_out=8'h00 same cycle; new en after release transfers correctly.
- SPI_LSB_FIRST_EN defined, data_in=8'h01 -> mosi high only during first bit; miso=1 only on first bit gives data_out=8'h01.
- Back-to-back: en in cycle after done with data_in=8'hFF -> accepted; ss high exactly 1 cycle between transfers.
